// File: rtl/cursor_ctrl.sv
// rtl/cursor_ctrl.sv - Battleship targeting cursor, fired-cell bitmap and shot FIFO
// Optional feature macro: CURSOR_WRAP_EN (cursor wraps at grid edges; default saturates).
module cursor_ctrl #(
  parameter int GRID_W     = 10,
  parameter int GRID_H     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [1:0] kb_dir,
  input  logic       kb_fire,
  input  logic       kb_done,
  input  logic       enable,
  input  logic       new_game,
  output logic [3:0] cur_x,
  output logic [3:0] cur_y,
  output logic       shot_valid,
  output logic [3:0] shot_x,
  output logic [3:0] shot_y,
  input  logic       shot_ready,
  output logic       dup_shot,
  output logic       ovf
);

  localparam int BW = GRID_W * GRID_H;
  localparam int IW = (BW > 1) ? $clog2(BW) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [3:0]    X_MAX    = 4'(GRID_W - 1);
  localparam logic [3:0]    Y_MAX    = 4'(GRID_H - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_APPLY} state_t;

  state_t        r_state;
  logic          r_ev_fire;
  logic [1:0]    r_ev_dir;
  logic [3:0]    r_cur_x;
  logic [3:0]    r_cur_y;
  logic          r_dup;
  logic          r_ovf;
  logic [BW-1:0] r_bitmap;
  logic [3:0]    r_mem_x [FIFO_DEPTH];
  logic [3:0]    r_mem_y [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_ev;
  logic          w_fire;
  logic          w_move;
  logic [7:0]    w_idx8;
  logic [IW-1:0] w_bit;
  logic          w_hit;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [3:0]    w_nx_x;
  logic [3:0]    w_nx_y;

  // Event qualification, bitmap lookup, FIFO handshake and next cursor position
  always_comb begin
    w_ev    = kb_done & enable & ~new_game;
    w_fire  = (r_state == S_APPLY) & r_ev_fire;
    w_move  = (r_state == S_APPLY) & ~r_ev_fire;
    w_idx8  = 8'(r_cur_y) * 8'(GRID_W) + 8'(r_cur_x);
    w_bit   = IW'(w_idx8);
    w_hit   = r_bitmap[w_bit];
    w_empty = (r_count == '0);
    w_full  = (r_count == FULL_CNT);
    w_pop   = ~w_empty & shot_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept the shot
    w_push  = w_fire & ~w_hit & (~w_full | w_pop);
    w_drop  = w_fire & ~w_hit & w_full & ~w_pop;
    w_nx_x  = r_cur_x;
    w_nx_y  = r_cur_y;
    case (r_ev_dir)
`ifdef CURSOR_WRAP_EN
      2'b00:   w_nx_y = (r_cur_y == 4'd0)  ? Y_MAX : r_cur_y - 4'd1;
      2'b01:   w_nx_y = (r_cur_y == Y_MAX) ? 4'd0  : r_cur_y + 4'd1;
      2'b10:   w_nx_x = (r_cur_x == 4'd0)  ? X_MAX : r_cur_x - 4'd1;
      default: w_nx_x = (r_cur_x == X_MAX) ? 4'd0  : r_cur_x + 4'd1;
`else
      2'b00:   w_nx_y = (r_cur_y == 4'd0)  ? r_cur_y : r_cur_y - 4'd1;
      2'b01:   w_nx_y = (r_cur_y == Y_MAX) ? r_cur_y : r_cur_y + 4'd1;
      2'b10:   w_nx_x = (r_cur_x == 4'd0)  ? r_cur_x : r_cur_x - 4'd1;
      default: w_nx_x = (r_cur_x == X_MAX) ? r_cur_x : r_cur_x + 4'd1;
`endif
    endcase
  end

  // Controller FSM: latch one event, apply it next cycle, restart on new_game
  always_ff @(posedge sys_clk) begin
    if (rst || new_game) begin
      r_state   <= S_IDLE;
      r_ev_fire <= 1'b0;
      r_ev_dir  <= 2'b00;
      r_cur_x   <= 4'd0;
      r_cur_y   <= 4'd0;
      r_dup     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_dup <= w_fire & w_hit;
      if (w_drop) r_ovf <= 1'b1;
      if (w_move) begin
        r_cur_x <= w_nx_x;
        r_cur_y <= w_nx_y;
      end
      case (r_state)
        S_IDLE, S_APPLY: begin
          // An event arriving during APPLY is latched and applied back-to-back
          if (w_ev) begin
            r_ev_fire <= kb_fire;
            r_ev_dir  <= kb_dir;
            r_state   <= S_APPLY;
          end else begin
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Shot FIFO storage, pointers, occupancy and fired-cell bitmap
  always_ff @(posedge sys_clk) begin
    if (rst || new_game) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_bitmap <= '0;
    end else begin
      if (w_push) begin
        r_mem_x[r_wr_ptr] <= r_cur_x;
        r_mem_y[r_wr_ptr] <= r_cur_y;
        r_wr_ptr          <= r_wr_ptr + PW'(1);
        r_bitmap[w_bit]   <= 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign cur_x      = r_cur_x;
  assign cur_y      = r_cur_y;
  assign shot_valid = ~w_empty;
  assign shot_x     = w_empty ? 4'd0 : r_mem_x[r_rd_ptr];
  assign shot_y     = w_empty ? 4'd0 : r_mem_y[r_rd_ptr];
  assign dup_shot   = r_dup;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_cursor_ctrl.sv
// tb/tb_cursor_ctrl.sv - scoreboard bench for cursor_ctrl
module tb_cursor_ctrl;
  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] kb_dir = 2'b00;
  logic       kb_fire = 1'b0;
  logic       kb_done = 1'b0;
  logic       enable = 1'b1;
  logic       new_game = 1'b0;
  logic [3:0] cur_x, cur_y, shot_x, shot_y;
  logic       shot_valid, shot_ready, dup_shot, ovf;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
  } shot_t;

  shot_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    pops = 0;
  int    pops_before;

  initial shot_ready = 1'b0;

  cursor_ctrl #(.GRID_W(10), .GRID_H(10), .FIFO_DEPTH(4)) dut (
    .sys_clk(sys_clk), .rst(rst), .kb_dir(kb_dir), .kb_fire(kb_fire),
    .kb_done(kb_done), .enable(enable), .new_game(new_game),
    .cur_x(cur_x), .cur_y(cur_y), .shot_valid(shot_valid),
    .shot_x(shot_x), .shot_y(shot_y), .shot_ready(shot_ready),
    .dup_shot(dup_shot), .ovf(ovf)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted handshake must match the oldest expected shot
  always @(negedge sys_clk) begin
    shot_t e;
    if (!rst && !new_game && shot_valid === 1'b1 && shot_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_shot: got (%0d,%0d) expected none", shot_x, shot_y);
      end else begin
        e = exp_q.pop_front();
        check("shot_x", {4'd0, shot_x}, {4'd0, e.x});
        check("shot_y", {4'd0, shot_y}, {4'd0, e.y});
        pops++;
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] d, input logic f);
    kb_dir  = d;
    kb_fire = f;
    kb_done = 1'b1;
    tick();
    kb_done = 1'b0;
    kb_fire = 1'b0;
    kb_dir  = 2'b00;
  endtask

  task automatic move(input logic [1:0] d);
    strobe(d, 1'b0);
    tick();
  endtask

  task automatic fire_push(input logic [3:0] x, input logic [3:0] y);
    exp_q.push_back('{x, y});
    strobe(2'b11, 1'b1);
    tick();
  endtask

  task automatic drain();
    int n = 0;
    shot_ready = 1'b1;
    while (shot_valid === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    shot_ready = 1'b0;
    check("drain_empty", {7'd0, shot_valid}, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    check("rst_cur_x", {4'd0, cur_x}, 8'd0);
    check("rst_cur_y", {4'd0, cur_y}, 8'd0);
    check("rst_valid", {7'd0, shot_valid}, 8'd0);
    check("rst_shot_x", {4'd0, shot_x}, 8'd0);
    check("rst_shot_y", {4'd0, shot_y}, 8'd0);
    check("rst_dup", {7'd0, dup_shot}, 8'd0);
    check("rst_ovf", {7'd0, ovf}, 8'd0);

    // Left at the origin edge
    move(2'b10);
`ifdef CURSOR_WRAP_EN
    check("left_wrap", {4'd0, cur_x}, 8'd9);
    move(2'b11);
    check("right_wrap", {4'd0, cur_x}, 8'd0);
`else
    check("left_clamp", {4'd0, cur_x}, 8'd0);
`endif

    // Four rights and two downs with two-cycle latency each
    for (int i = 0; i < 4; i++) begin
      strobe(2'b11, 1'b0);
      check("right_n1", {4'd0, cur_x}, 8'(i));
      tick();
      check("right_n2", {4'd0, cur_x}, 8'(i + 1));
    end
    for (int i = 0; i < 2; i++) begin
      strobe(2'b01, 1'b0);
      check("down_n1", {4'd0, cur_y}, 8'(i));
      tick();
      check("down_n2", {4'd0, cur_y}, 8'(i + 1));
    end

    // Move to (3,5) and fire
    move(2'b10);
    repeat (3) move(2'b01);
    exp_q.push_back('{4'd3, 4'd5});
    strobe(2'b11, 1'b1);
    check("fire_n1_valid", {7'd0, shot_valid}, 8'd0);
    tick();
    check("fire_n2_valid", {7'd0, shot_valid}, 8'd1);
    check("fire_n2_x", {4'd0, shot_x}, 8'd3);
    check("fire_n2_y", {4'd0, shot_y}, 8'd5);

    // Duplicate fire on the same cell
    strobe(2'b11, 1'b1);
    check("dup_n1", {7'd0, dup_shot}, 8'd0);
    tick();
    check("dup_n2", {7'd0, dup_shot}, 8'd1);
    tick();
    check("dup_n3", {7'd0, dup_shot}, 8'd0);
    pops_before = pops;
    drain();
    check("dup_no_push", 8'(pops - pops_before), 8'd1);

    // Fill the FIFO and overflow with a fifth distinct cell
    for (int i = 0; i < 4; i++) begin
      move(2'b11);
      fire_push(4'(4 + i), 4'd5);
    end
    check("ovf_before", {7'd0, ovf}, 8'd0);
    move(2'b11);
    strobe(2'b11, 1'b1);
    tick();
    check("ovf_set", {7'd0, ovf}, 8'd1);
    check("ovf_no_dup", {7'd0, dup_shot}, 8'd0);
    shot_ready = 1'b1;
    tick();
    shot_ready = 1'b0;
    fire_push(4'd8, 4'd5);
    check("refire_no_dup", {7'd0, dup_shot}, 8'd0);
    check("ovf_sticky", {7'd0, ovf}, 8'd1);
    pops_before = pops;
    drain();
    check("refire_count", 8'(pops - pops_before), 8'd4);

    // enable low blocks new events
    enable = 1'b0;
    move(2'b10);
    check("enable_block", {4'd0, cur_x}, 8'd8);
    enable = 1'b1;

    // new_game clears cursor and ovf
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check("ng_cur_x", {4'd0, cur_x}, 8'd0);
    check("ng_cur_y", {4'd0, cur_y}, 8'd0);
    check("ng_ovf", {7'd0, ovf}, 8'd0);

    // Full FIFO with a fire landing on a pop cycle
    fire_push(4'd0, 4'd0);
    for (int i = 1; i < 4; i++) begin
      move(2'b11);
      fire_push(4'(i), 4'd0);
    end
    move(2'b11);
    exp_q.push_back('{4'd4, 4'd0});
    strobe(2'b11, 1'b1);
    shot_ready = 1'b1;
    tick();
    shot_ready = 1'b0;
    check("full_pop_ovf", {7'd0, ovf}, 8'd0);
    check("full_pop_dup", {7'd0, dup_shot}, 8'd0);
    pops_before = pops;
    drain();
    check("full_pop_count", 8'(pops - pops_before), 8'd4);

    // new_game on the same cycle as a fire strobe, two entries queued
    move(2'b11);
    fire_push(4'd5, 4'd0);
    move(2'b11);
    fire_push(4'd6, 4'd0);
    kb_dir = 2'b11;
    kb_fire = 1'b1;
    kb_done = 1'b1;
    new_game = 1'b1;
    tick();
    kb_done = 1'b0;
    kb_fire = 1'b0;
    new_game = 1'b0;
    exp_q.delete();
    check("ng2_valid", {7'd0, shot_valid}, 8'd0);
    check("ng2_cur_x", {4'd0, cur_x}, 8'd0);
    check("ng2_cur_y", {4'd0, cur_y}, 8'd0);
    tick();
    check("ng2_discard", {7'd0, shot_valid}, 8'd0);
    fire_push(4'd0, 4'd0);
    check("ng2_refire_valid", {7'd0, shot_valid}, 8'd1);
    check("ng2_refire_dup", {7'd0, dup_shot}, 8'd0);
    drain();

    // Reset while a move is pending discards it
    strobe(2'b11, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rst_discard", {4'd0, cur_x}, 8'd0);

    check("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
